// File: rtl/stream_mux_4to1_pkg.sv
// Shared definitions for the 4-channel stream mux/demux pair.
// Channel count, select width and FSM encoding live here so both sides agree.
package stream_mux_4to1_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Channel after ch, wrapping from the last channel back to 0.
    function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] ch);
        return ch + SEL_W'(1);
    endfunction

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/stream_mux_4to1_if.sv
// Bundle of the mux's per-channel input streams and merged output stream.
// The slave view is the mux itself; the master view is its surrounding environment.
interface stream_mux_4to1_if
    import stream_mux_4to1_pkg::*;
#(
    parameter int WIDTH = 8
);

    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_last;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic                    out_last;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_sel;
    logic                    out_ready;

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_last, out_data, out_sel
    );

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_last, out_data, out_sel
    );

endinterface

// File: rtl/stream_mux_4to1_rr_arbiter_4.sv
// Combinational round-robin pick: first requesting channel at or after ptr, wrapping.
module rr_arbiter_4
    import stream_mux_4to1_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              gnt_vld,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] cand_s;
    logic             hit_s;

    // Scan from the farthest offset down so the closest requester to ptr is the last writer.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = {SEL_W{1'b0}};
        cand_s  = {SEL_W{1'b0}};
        hit_s   = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand_s  = ptr + SEL_W'(k);
            hit_s   = req[cand_s];
            gnt_vld = gnt_vld | hit_s;
            gnt_idx = hit_s ? cand_s : gnt_idx;
        end
    end

endmodule

// File: rtl/stream_mux_4to1.sv
// 4:1 packet-aware stream merger: round-robin between packets, grant held until in_last,
// single registered output stage tagged with the source channel in out_sel.
module stream_mux_4to1
    import stream_mux_4to1_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic              clk,
    input  logic              rst_n,
    stream_mux_4to1_if.slave  bus
);

    state_e            state_r;
    logic [SEL_W-1:0]  ptr_r;
    logic [SEL_W-1:0]  lock_idx_r;

    logic              out_valid_r;
    logic              out_last_r;
    logic [WIDTH-1:0]  out_data_r;
    logic [SEL_W-1:0]  out_sel_r;

    logic              arb_vld_s;
    logic [SEL_W-1:0]  arb_idx_s;
    logic              gnt_vld_s;
    logic [SEL_W-1:0]  gnt_idx_s;
    logic              load_s;
    logic [NUM_CH-1:0] ready_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic              sel_last_s;

    rr_arbiter_4 u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_r),
        .gnt_vld (arb_vld_s),
        .gnt_idx (arb_idx_s)
    );

    // Output register can take a new beat when empty or being drained this cycle.
    assign load_s = !out_valid_r || bus.out_ready;

    // Grant source: arbiter when idle; the locked channel owns the bus even while it idles.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_idx_s = {SEL_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                gnt_vld_s = arb_vld_s;
                gnt_idx_s = arb_idx_s;
            end
            ST_LOCKED: begin
                gnt_vld_s = 1'b1;
                gnt_idx_s = lock_idx_r;
            end
            default: begin
                gnt_vld_s = 1'b0;
                gnt_idx_s = {SEL_W{1'b0}};
            end
        endcase
    end

    // Ready goes only to the granted channel; gated by rst_n so nothing is accepted in reset.
    always_comb begin
        ready_s = {NUM_CH{1'b0}};
        if (rst_n && gnt_vld_s && load_s) begin
            ready_s = onehot(gnt_idx_s);
        end else begin
            ready_s = {NUM_CH{1'b0}};
        end
    end

    assign xfer_s     = |(ready_s & bus.in_valid);
    assign sel_data_s = bus.in_data[gnt_idx_s*WIDTH +: WIDTH];
    assign sel_last_s = bus.in_last[gnt_idx_s];

    // Packet lock FSM; the rr pointer only advances when a packet completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {SEL_W{1'b0}};
            lock_idx_r <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (sel_last_s) begin
                        ptr_r <= next_ch(gnt_idx_s);
                    end else begin
                        state_r    <= ST_LOCKED;
                        lock_idx_r <= gnt_idx_s;
                    end
                end
                ST_LOCKED: begin
                    if (sel_last_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= next_ch(lock_idx_r);
                    end else begin
                        state_r <= ST_LOCKED;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output stage: capture on transfer, empty on an idle load, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_last_r  <= sel_last_s;
            out_data_r  <= sel_data_s;
            out_sel_r   <= gnt_idx_s;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_sel   = out_sel_r;

endmodule
